// File: rtl/two_bit_fa_pkg.sv
// Shared constants for the registered program-counter incrementer.
package two_bit_fa_pkg;

    localparam int INC_MAX_WIDTH = 16;
    localparam logic [INC_MAX_WIDTH-1:0] INC_RESET_SUM = '0;

endpackage : two_bit_fa_pkg

// File: rtl/two_bit_fa_fa_cell.sv
// One-bit full adder cell; the incrementer chains WIDTH of these.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/two_bit_fa.sv
// Registered ripple-carry +1 for the program counter, with a sticky overflow flag.
module two_bit_fa
    import two_bit_fa_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
    output logic             ovf_sticky
);

    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             out_valid_reg;
    logic             ovf_sticky_reg;

    // Incrementing is adding zero with a carry-in of one.
    assign carry_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            fa_cell u_fa_cell (
                .a    (operand[gi]),
                .b    (1'b0),
                .cin  (carry_chain[gi]),
                .s    (sum_next[gi]),
                .cout (carry_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg        <= INC_RESET_SUM[WIDTH-1:0];
            carry_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg   <= sum_next;
                carry_reg <= carry_chain[WIDTH];
            end
            // A new overflow outranks a clear arriving in the same cycle.
            if (in_valid && carry_chain[WIDTH]) begin
                ovf_sticky_reg <= 1'b1;
            end else if (clear_ovf) begin
                ovf_sticky_reg <= 1'b0;
            end
        end
    end

    assign sum        = sum_reg;
    assign carry      = carry_reg;
    assign out_valid  = out_valid_reg;
    assign ovf_sticky = ovf_sticky_reg;

endmodule : two_bit_fa

// File: tb/tb_two_bit_fa.sv
// Scoreboard bench: 2-bit and 8-bit incrementers driven with directed vectors.
module tb_two_bit_fa;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid2, clear_ovf2;
    logic [1:0] operand2;
    logic [1:0] sum2;
    logic       carry2, out_valid2, ovf_sticky2;
    logic       in_valid8, clear_ovf8;
    logic [7:0] operand8;
    logic [7:0] sum8;
    logic       carry8, out_valid8, ovf_sticky8;

    int asserts = 0;
    int failures = 0;

    logic [2:0] exp_q2[$];
    logic [8:0] exp_q8[$];

    always #5 clk = ~clk;

    two_bit_fa #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .operand(operand2),
        .clear_ovf(clear_ovf2), .sum(sum2), .carry(carry2),
        .out_valid(out_valid2), .ovf_sticky(ovf_sticky2)
    );

    two_bit_fa #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .operand(operand8),
        .clear_ovf(clear_ovf8), .sum(sum8), .carry(carry8),
        .out_valid(out_valid8), .ovf_sticky(ovf_sticky8)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [1:0] op, input logic clr,
                          input logic [2:0] exp);
        in_valid2  = v;
        operand2   = op;
        clear_ovf2 = clr;
        if (v && !reset) exp_q2.push_back(exp);
        cyc();
    endtask

    task automatic drive8(input logic v, input logic [7:0] op, input logic [8:0] exp);
        in_valid8 = v;
        operand8  = op;
        if (v && !reset) exp_q8.push_back(exp);
        cyc();
    endtask

    // Monitors: pop one expected {carry,sum} per out_valid cycle.
    always @(negedge clk) begin
        if (out_valid2) begin
            if (exp_q2.size() == 0) begin
                asserts++;
                failures++;
                $display("FAIL w2_unexpected_valid: got sum=%0h carry=%0b, expected none", sum2, carry2);
            end else begin
                logic [2:0] e;
                e = exp_q2.pop_front();
                check("w2_sum", {14'd0, sum2}, {14'd0, e[1:0]});
                check("w2_carry", {15'd0, carry2}, {15'd0, e[2]});
            end
        end
        if (out_valid8) begin
            if (exp_q8.size() == 0) begin
                asserts++;
                failures++;
                $display("FAIL w8_unexpected_valid: got sum=%0h carry=%0b, expected none", sum8, carry8);
            end else begin
                logic [8:0] e;
                e = exp_q8.pop_front();
                check("w8_sum", {8'd0, sum8}, {8'd0, e[7:0]});
                check("w8_carry", {15'd0, carry8}, {15'd0, e[8]});
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid2 = 1'b1; operand2 = 2'd3; clear_ovf2 = 1'b0;
        in_valid8 = 1'b1; operand8 = 8'hFF; clear_ovf8 = 1'b0;
        cyc();
        cyc();
        check("rst_sum", {14'd0, sum2}, 16'd0);
        check("rst_carry", {15'd0, carry2}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid2}, 16'd0);
        check("rst_ovf_sticky", {15'd0, ovf_sticky2}, 16'd0);
        check("rst_w8_out_valid", {15'd0, out_valid8}, 16'd0);
        reset = 1'b0;
        in_valid8 = 1'b0;

        // Exhaustive sweep, back to back
        drive2(1'b1, 2'd0, 1'b0, {1'b0, 2'd1});
        check("sweep_valid0", {15'd0, out_valid2}, 16'd1);
        drive2(1'b1, 2'd1, 1'b0, {1'b0, 2'd2});
        check("sweep_valid1", {15'd0, out_valid2}, 16'd1);
        drive2(1'b1, 2'd2, 1'b0, {1'b0, 2'd3});
        check("sweep_valid2", {15'd0, out_valid2}, 16'd1);
        drive2(1'b1, 2'd3, 1'b0, {1'b1, 2'd0});
        check("sweep_valid3", {15'd0, out_valid2}, 16'd1);
        check("sweep_sticky", {15'd0, ovf_sticky2}, 16'd1);
        drive2(1'b0, 2'd0, 1'b1, 3'd0);
        check("sweep_clear", {15'd0, ovf_sticky2}, 16'd0);

        // Hold
        drive2(1'b1, 2'd2, 1'b0, {1'b0, 2'd3});
        drive2(1'b0, 2'd3, 1'b0, 3'd0);
        check("hold_sum", {14'd0, sum2}, 16'd3);
        check("hold_carry", {15'd0, carry2}, 16'd0);
        check("hold_out_valid", {15'd0, out_valid2}, 16'd0);

        // Sticky set / keep / clear
        drive2(1'b1, 2'd3, 1'b0, {1'b1, 2'd0});
        check("sticky_set", {15'd0, ovf_sticky2}, 16'd1);
        drive2(1'b1, 2'd0, 1'b0, {1'b0, 2'd1});
        check("sticky_keep", {15'd0, ovf_sticky2}, 16'd1);
        drive2(1'b0, 2'd0, 1'b1, 3'd0);
        check("sticky_clear", {15'd0, ovf_sticky2}, 16'd0);

        // Simultaneous set and clear: set wins
        drive2(1'b1, 2'd3, 1'b1, {1'b1, 2'd0});
        check("setclr_sticky", {15'd0, ovf_sticky2}, 16'd1);
        check("setclr_carry", {15'd0, carry2}, 16'd1);
        drive2(1'b0, 2'd0, 1'b0, 3'd0);

        // 8-bit instance
        drive8(1'b1, 8'h7F, {1'b0, 8'h80});
        drive8(1'b1, 8'hFF, {1'b1, 8'h00});
        check("w8_sticky", {15'd0, ovf_sticky8}, 16'd1);
        drive8(1'b1, 8'h00, {1'b0, 8'h01});
        drive8(1'b0, 8'h00, 9'd0);

        cyc();
        cyc();
        check("w2_queue_drained", 16'(exp_q2.size()), 16'd0);
        check("w8_queue_drained", 16'(exp_q8.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule : tb_two_bit_fa

// File: doc/two_bit_fa.md
# two_bit_fa

Registered ripple-carry incrementer for the paper processor's program-counter path. It adds one to a WIDTH-bit operand (default 2 bits, matching the counter register) and returns the wrapped sum to the counter input. The carry-out goes to the status register as the overflow indication. It also keeps a sticky overflow flag that the control unit can read and clear.

## Interface
Parameters:
- WIDTH, 2, operand/sum width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- in_valid  input  1  operand is presented this cycle; the increment is performed.
- operand  input  WIDTH  current counter value (the `out` bus of the counter).
- clear_ovf  input  1  clears the sticky overflow flag.
- sum  output  WIDTH  registered operand + 1, modulo 2^WIDTH (to the counter input).
- carry  output  1  registered carry-out of the increment (to the status register).
- out_valid  output  1  sum/carry hold a result produced from an accepted operand.
- ovf_sticky  output  1  set when any accepted increment produced carry = 1.

## Operation
- Combinational core: a WIDTH-stage ripple chain of full-adder cells.
  - Stage 0: a = operand[0], b = 0, cin = 1.
  - Stage i: a = operand[i], b = 0, cin = cout of stage i-1.
  - Final cout is the carry.
- Accepted cycle (in_valid = 1, reset = 0):
  - sum <= operand + 1 (truncated to WIDTH bits).
  - carry <= 1 exactly when operand = all ones, otherwise 0.
  - out_valid <= 1.
- Idle cycle (in_valid = 0): sum and carry hold their previous values; out_valid <= 0.
- Sticky flag update:
  - Set on any accepted cycle with carry result 1.
  - clear_ovf = 1 clears it.
  - Simultaneous set and clear: set wins (the flag reads 1 next cycle).
- No back-pressure; every in_valid cycle is consumed.

## Timing
- Latency: 1 cycle. An operand sampled at edge N appears on sum/carry after edge N, with out_valid high for that one cycle.
- Throughput: one increment per cycle; back-to-back in_valid is supported.
- Reset values: sum = 0, carry = 0, out_valid = 0, ovf_sticky = 0.
- Reset has priority over in_valid and clear_ovf. An operand presented in the reset cycle is discarded.
- Wrap-around: all ones -> sum 0, carry 1. For WIDTH = 2: 3 -> 0 with carry 1, and 0 -> 1, 1 -> 2, 2 -> 3 with carry 0.
- Outputs are driven only from flops; there is no combinational path from input to output.
- The ripple chain must close timing within one clk period for WIDTH <= 16.

## Structure
- Shared package constants:
  - INC_MAX_WIDTH = 16.
  - INC_RESET_SUM = '0.
- One sub-module, fa_cell: 1-bit full adder.
  - Inputs a, b, cin; outputs s, cout.
  - s = a ^ b ^ cin; cout = majority(a, b, cin).
- The top instantiates WIDTH copies of fa_cell in a generate loop, plus the output and sticky registers.
- No other hierarchy.

## Test plan
- Reset: assert reset for 2 cycles with in_valid = 1 and operand = 3 -> sum = 0, carry = 0, out_valid = 0, ovf_sticky = 0.
- Exhaustive sweep, WIDTH = 2: operands 0, 1, 2, 3 on consecutive cycles -> sums 1, 2, 3, 0 and carries 0, 0, 0, 1, each one cycle later, with out_valid continuously high.
- Hold: operand = 2 accepted, then in_valid = 0 with operand = 3 -> sum stays 3, carry stays 0, out_valid drops to 0.
- Sticky set/clear: accept operand = 3 -> ovf_sticky = 1; then accept operand = 0 -> ovf_sticky stays 1; pulse clear_ovf -> ovf_sticky = 0.
- Simultaneous set and clear: clear_ovf = 1 in the same cycle as accepted operand = 3 -> ovf_sticky = 1, carry = 1.
- WIDTH = 8: operand 0x7F -> sum 0x80, carry 0; operand 0xFF -> sum 0x00, carry 1.
